cpucr_fetch: RTL

Instruction fetch sequencer for the CPUCR system, sitting directly upstream of main memory. It owns the memory address bus and reads the opcode and its operand bytes, assembling 16-bit little-endian operands. For indirect opcodes it chases the two-byte pointer to form the effective address. It then presents one complete instruction per valid/ready handshake to the execution stage.

---
 rtl/cpucr_pkg.sv | 27 ++
 rtl/cpucr_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpucr_pkg.sv
// Shared CPUCR definitions: fetch sequencer states, operand-length encoding
// and the default reset program counter.
package cpucr_pkg;

  typedef enum logic [2:0] {
    ST_OPC,
    ST_OPL,
    ST_OPH,
    ST_PTRL,
    ST_PTRH,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

  localparam logic [1:0] OPLEN_0 = 2'd0;
  localparam logic [1:0] OPLEN_1 = 2'd1;
  localparam logic [1:0] OPLEN_2 = 2'd2;
  localparam logic [1:0] OPLEN_3 = 2'd3;

  localparam logic [15:0] CPUCR_RESET_PC = 16'h0000;

  // The decoder may report 3 operand bytes; the fetch path never reads more than 2.
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == OPLEN_3) ? OPLEN_2 : len;
  endfunction

endpackage

// File: rtl/cpucr_fetch.sv
// CPUCR instruction fetch sequencer: reads opcode and little-endian operand
// bytes, chases indirect pointers, and hands one instruction per handshake.
module cpucr_fetch
  import cpucr_pkg::*;
#(
  parameter logic [15:0] RESET_PC = CPUCR_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] Direccion,
  input  logic [7:0]  Datos,
  output logic        LE,
  output logic [7:0]  dec_op,
  input  logic [1:0]  op_len,
  input  logic        op_ind,
  input  logic        op_hlt,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [7:0]  ins_opcode,
  output logic [15:0] ins_operand,
  output logic [15:0] ins_ea,
  output logic [15:0] ins_pc,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  operand_q, operand_d;
  logic [15:0]  ea_q, ea_d;
  logic [15:0]  ipc_q, ipc_d;
  logic [1:0]   len;

  assign len = eff_len(op_len);

  // The decoder sees the live bus during OPC so the length is known at the latching edge.
  assign dec_op = (state_q == ST_OPC) ? Datos : opcode_q;

  always_comb begin
    Direccion = pc_q;
    case (state_q)
      ST_PTRL: Direccion = operand_q;
      ST_PTRH: Direccion = operand_q + 16'd1;
      default: Direccion = pc_q;
    endcase
  end

  assign LE          = 1'b1;
  assign ins_valid   = (state_q == ST_HOLD);
  assign ins_opcode  = opcode_q;
  assign ins_operand = operand_q;
  assign ins_ea      = ea_q;
  assign ins_pc      = ipc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    ea_d      = ea_q;
    ipc_d     = ipc_q;
    case (state_q)
      ST_OPC: begin
        opcode_d  = Datos;
        ipc_d     = pc_q;
        pc_d      = pc_q + 16'd1;
        operand_d = '0;
        ea_d      = '0;
        state_d   = (len == OPLEN_0) ? ST_HOLD : ST_OPL;
      end
      ST_OPL: begin
        operand_d = {8'h00, Datos};
        ea_d      = {8'h00, Datos};
        pc_d      = pc_q + 16'd1;
        state_d   = (len == OPLEN_2) ? ST_OPH : ST_HOLD;
      end
      ST_OPH: begin
        // ea tracks the operand so direct instructions need no extra step.
        operand_d = {Datos, operand_q[7:0]};
        ea_d      = {Datos, operand_q[7:0]};
        pc_d      = pc_q + 16'd1;
        state_d   = op_ind ? ST_PTRL : ST_HOLD;
      end
      ST_PTRL: begin
        ea_d[7:0] = Datos;
        state_d   = ST_PTRH;
      end
      ST_PTRH: begin
        ea_d[15:8] = Datos;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (ins_ready) begin
          if (pc_load) pc_d = pc_load_val;
          state_d = op_hlt ? ST_HALT : ST_OPC;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_OPC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OPC;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      operand_q <= '0;
      ea_q      <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ea_q      <= ea_d;
      ipc_q     <= ipc_d;
    end
  end

endmodule
